register_file_sb: RTL and testbench

Parametrised multi-read-port register file with scoreboard, for the next-generation DiBU datapath.
- Allows a read and a write in the same cycle. Registered reads have write-through bypass.
- Per-register busy bits let the decoder reserve a destination for a multi-cycle op and detect RAW hazards.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes).

---
 rtl/dibu_rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 56 +++++
 rtl/register_file_sb.sv | 102 ++++++++++
 tb/tb_register_file_sb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dibu_rf_pkg.sv
// Shared constants and index qualification for the DiBU register file.
package dibu_rf_pkg;

   localparam int unsigned DefaultDw   = 8;
   localparam int unsigned DefaultNreg = 8;
   localparam int unsigned DefaultNrd  = 2;

   // An index addresses real storage only if in range and not a hardwired-zero r0.
   function automatic logic idx_valid(input int unsigned idx, input int unsigned nreg,
                                      input logic zero_r0);
      return (idx < nreg) && !(zero_r0 && (idx == 0));
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reservation sets, writeback clears, reservation wins on a tie.
module rf_scoreboard
   import dibu_rf_pkg::*;
#(
   parameter int unsigned NREG    = DefaultNreg,
   parameter int unsigned AW      = $clog2(NREG),
   parameter int unsigned NRD     = DefaultNrd,
   parameter bit          ZERO_R0 = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_idx,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_idx,
   input  logic [NRD*AW-1:0]   rd_idx,
   output logic [NREG-1:0]     busy_vec,
   output logic [NRD-1:0]      busy_post
);

   logic [NREG-1:0] busy_q, busy_d;
   logic            wr_ok, rsv_ok;

   always_comb begin
      wr_ok  = wr_en && idx_valid(32'(wr_idx), NREG, ZERO_R0);
      rsv_ok = rsv_en && idx_valid(32'(rsv_idx), NREG, ZERO_R0);
      busy_d = busy_q;
      for (int i = 0; i < int'(NREG); i++) begin
         if (wr_ok && (wr_idx == AW'(i))) busy_d[i] = 1'b0;
         if (rsv_ok && (rsv_idx == AW'(i))) busy_d[i] = 1'b1;
      end
   end

   // Lookup against busy_d so a read sees this edge's set/clear outcome.
   always_comb begin
      logic [AW-1:0] idx;
      idx       = '0;
      busy_post = '0;
      for (int p = 0; p < int'(NRD); p++) begin
         idx = rd_idx[p*AW +: AW];
         if (idx_valid(32'(idx), NREG, ZERO_R0)) begin
            for (int i = 0; i < int'(NREG); i++) begin
               if (idx == AW'(i)) busy_post[p] = busy_d[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with registered, write-through reads and a busy scoreboard.
module register_file_sb
   import dibu_rf_pkg::*;
#(
   parameter int unsigned DW      = DefaultDw,
   parameter int unsigned NREG    = DefaultNreg,
   parameter int unsigned AW      = $clog2(NREG),
   parameter int unsigned NRD     = DefaultNrd,
   parameter bit          ZERO_R0 = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_en,
   input  logic [NRD*AW-1:0]   rd_idx,
   output logic [NRD*DW-1:0]   rd_data,
   output logic [NRD-1:0]      rd_busy,
   output logic                rd_valid,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_idx,
   input  logic [DW-1:0]       wr_data,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_idx,
   output logic [NREG-1:0]     busy_vec
);

   logic [DW-1:0]     mem_q [NREG];
   logic [DW-1:0]     mem_d [NREG];
   logic [NRD*DW-1:0] rd_data_q, rd_data_d;
   logic [NRD-1:0]    rd_busy_q, rd_busy_d;
   logic              rd_valid_q, rd_valid_d;
   logic [NRD-1:0]    busy_post;
   logic              wr_ok;

   rf_scoreboard #(
      .NREG    (NREG),
      .AW      (AW),
      .NRD     (NRD),
      .ZERO_R0 (ZERO_R0)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .rsv_en    (rsv_en),
      .rsv_idx   (rsv_idx),
      .rd_idx    (rd_idx),
      .busy_vec  (busy_vec),
      .busy_post (busy_post)
   );

   always_comb begin
      wr_ok = wr_en && idx_valid(32'(wr_idx), NREG, ZERO_R0);
      for (int i = 0; i < int'(NREG); i++) begin
         mem_d[i] = mem_q[i];
         if (wr_ok && (wr_idx == AW'(i))) mem_d[i] = wr_data;
      end
   end

   // Invalid indices (out of range or hardwired r0) read as zero and never bypass.
   always_comb begin
      logic [AW-1:0] idx;
      idx        = '0;
      rd_data_d  = rd_data_q;
      rd_busy_d  = rd_busy_q;
      rd_valid_d = rd_en;
      if (rd_en) begin
         rd_busy_d = busy_post;
         for (int p = 0; p < int'(NRD); p++) begin
            idx                   = rd_idx[p*AW +: AW];
            rd_data_d[p*DW +: DW] = '0;
            if (idx_valid(32'(idx), NREG, ZERO_R0)) begin
               if (wr_ok && (wr_idx == idx)) begin
                  rd_data_d[p*DW +: DW] = wr_data;
               end else begin
                  for (int i = 0; i < int'(NREG); i++) begin
                     if (idx == AW'(i)) rd_data_d[p*DW +: DW] = mem_q[i];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
         rd_data_q  <= '0;
         rd_busy_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NREG); i++) mem_q[i] <= mem_d[i];
         rd_data_q  <= rd_data_d;
         rd_busy_q  <= rd_busy_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_busy  = rd_busy_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: a default instance (NREG=8) and a ZERO_R0=1, NREG=6 instance.
module tb_register_file_sb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: NREG=8, ZERO_R0=0
   logic       a_rd_en, a_wr_en, a_rsv_en;
   logic [5:0] a_rd_idx;
   logic [2:0] a_wr_idx, a_rsv_idx;
   logic [7:0] a_wr_data, a_bv;
   logic [15:0] a_rd_data;
   logic [1:0] a_rd_busy;
   logic       a_rd_valid;

   // Instance B: NREG=6, ZERO_R0=1
   logic       b_rd_en, b_wr_en, b_rsv_en;
   logic [5:0] b_rd_idx;
   logic [2:0] b_wr_idx, b_rsv_idx;
   logic [7:0] b_wr_data;
   logic [5:0] b_bv;
   logic [15:0] b_rd_data;
   logic [1:0] b_rd_busy;
   logic       b_rd_valid;

   register_file_sb #(.DW(8), .NREG(8), .NRD(2), .ZERO_R0(1'b0)) dut_a (
      .clk(clk), .rst(rst), .rd_en(a_rd_en), .rd_idx(a_rd_idx), .rd_data(a_rd_data),
      .rd_busy(a_rd_busy), .rd_valid(a_rd_valid), .wr_en(a_wr_en), .wr_idx(a_wr_idx),
      .wr_data(a_wr_data), .rsv_en(a_rsv_en), .rsv_idx(a_rsv_idx), .busy_vec(a_bv)
   );

   register_file_sb #(.DW(8), .NREG(6), .NRD(2), .ZERO_R0(1'b1)) dut_b (
      .clk(clk), .rst(rst), .rd_en(b_rd_en), .rd_idx(b_rd_idx), .rd_data(b_rd_data),
      .rd_busy(b_rd_busy), .rd_valid(b_rd_valid), .wr_en(b_wr_en), .wr_idx(b_wr_idx),
      .wr_data(b_wr_data), .rsv_en(b_rsv_en), .rsv_idx(b_rsv_idx), .busy_vec(b_bv)
   );

   typedef struct {
      logic       rd_en;
      logic [2:0] ri0, ri1;
      logic       wr_en;
      logic [2:0] wi;
      logic [7:0] wd;
      logic       rsv_en;
      logic [2:0] si;
      logic [7:0] e_d0, e_d1;
      logic [1:0] e_busy;
      logic       e_valid;
      logic [7:0] e_bv;
   } vec_t;

   vec_t tbl [12];
   vec_t exp_q [$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic drive_a(input logic rd_en, input logic [2:0] ri0, input logic [2:0] ri1,
                          input logic wr_en, input logic [2:0] wi, input logic [7:0] wd,
                          input logic rsv_en, input logic [2:0] si);
      a_rd_en = rd_en; a_rd_idx = {ri1, ri0};
      a_wr_en = wr_en; a_wr_idx = wi; a_wr_data = wd;
      a_rsv_en = rsv_en; a_rsv_idx = si;
   endtask

   task automatic drive_b(input logic rd_en, input logic [2:0] ri0, input logic [2:0] ri1,
                          input logic wr_en, input logic [2:0] wi, input logic [7:0] wd,
                          input logic rsv_en, input logic [2:0] si);
      b_rd_en = rd_en; b_rd_idx = {ri1, ri0};
      b_wr_en = wr_en; b_wr_idx = wi; b_wr_data = wd;
      b_rsv_en = rsv_en; b_rsv_idx = si;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] busy, input logic valid, input logic [7:0] bv);
      chk({tag, ".d0"}, 32'(a_rd_data[7:0]), 32'(d0));
      chk({tag, ".d1"}, 32'(a_rd_data[15:8]), 32'(d1));
      chk({tag, ".busy"}, 32'(a_rd_busy), 32'(busy));
      chk({tag, ".valid"}, 32'(a_rd_valid), 32'(valid));
      chk({tag, ".bv"}, 32'(a_bv), 32'(bv));
   endtask

   task automatic chk_b(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] busy, input logic valid, input logic [5:0] bv);
      chk({tag, ".d0"}, 32'(b_rd_data[7:0]), 32'(d0));
      chk({tag, ".d1"}, 32'(b_rd_data[15:8]), 32'(d1));
      chk({tag, ".busy"}, 32'(b_rd_busy), 32'(busy));
      chk({tag, ".valid"}, 32'(b_rd_valid), 32'(valid));
      chk({tag, ".bv"}, 32'(b_bv), 32'(bv));
   endtask

   initial begin
      // rd_en ri0 ri1 wr wi wd rsv si | d0 d1 busy valid bv (state after the edge)
      tbl[0]  = '{1'b1, 3'd0, 3'd7, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0,
                  8'h00, 8'h00, 2'b00, 1'b1, 8'h00};
      tbl[1]  = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0,
                  8'h00, 8'h00, 2'b00, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0,
                  8'hA5, 8'hA5, 2'b00, 1'b1, 8'h00};
      tbl[3]  = '{1'b1, 3'd5, 3'd3, 1'b1, 3'd5, 8'h3C, 1'b0, 3'd0,
                  8'h3C, 8'hA5, 2'b00, 1'b1, 8'h00};
      tbl[4]  = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2,
                  8'h3C, 8'hA5, 2'b00, 1'b0, 8'h04};
      tbl[5]  = '{1'b1, 3'd2, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0,
                  8'h00, 8'h3C, 2'b01, 1'b1, 8'h04};
      tbl[6]  = '{1'b1, 3'd2, 3'd2, 1'b1, 3'd2, 8'h11, 1'b0, 3'd0,
                  8'h11, 8'h11, 2'b00, 1'b1, 8'h00};
      tbl[7]  = '{1'b1, 3'd2, 3'd0, 1'b1, 3'd2, 8'h5A, 1'b1, 3'd2,
                  8'h5A, 8'h00, 2'b01, 1'b1, 8'h04};
      tbl[8]  = '{1'b1, 3'd2, 3'd7, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0,
                  8'h5A, 8'h00, 2'b01, 1'b1, 8'h04};
      tbl[9]  = '{1'b1, 3'd7, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7,
                  8'h00, 8'h5A, 2'b11, 1'b1, 8'h84};
      tbl[10] = '{1'b1, 3'd7, 3'd7, 1'b1, 3'd7, 8'hC3, 1'b0, 3'd0,
                  8'hC3, 8'hC3, 2'b00, 1'b1, 8'h04};
      tbl[11] = '{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0,
                  8'hC3, 8'hC3, 2'b00, 1'b0, 8'h04};

      drive_a(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      drive_b(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      #12;
      chk_a("reset_a", 8'h00, 8'h00, 2'b00, 1'b0, 8'h00);
      chk_b("reset_b", 8'h00, 8'h00, 2'b00, 1'b0, 6'h00);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         vec_t v;
         @(negedge clk);
         drive_a(tbl[i].rd_en, tbl[i].ri0, tbl[i].ri1, tbl[i].wr_en, tbl[i].wi, tbl[i].wd,
                 tbl[i].rsv_en, tbl[i].si);
         exp_q.push_back(tbl[i]);
         edge_sample();
         v = exp_q.pop_front();
         chk_a($sformatf("vec%0d", i), v.e_d0, v.e_d1, v.e_busy, v.e_valid, v.e_bv);
      end
      @(negedge clk);
      drive_a(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

      // r0 hardwired to zero; indices 6 and 7 lie outside a 6-entry file.
      drive_b(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0);
      edge_sample();
      chk("b_r0_rsv.bv", 32'(b_bv), 32'h0);
      @(negedge clk);
      drive_b(1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0);
      edge_sample();
      chk_b("b_r0_read", 8'h00, 8'h00, 2'b00, 1'b1, 6'h00);
      @(negedge clk);
      drive_b(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 8'h99, 1'b1, 3'd7);
      edge_sample();
      chk("b_oor_rsv.bv", 32'(b_bv), 32'h0);
      @(negedge clk);
      drive_b(1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 8'h44, 1'b1, 3'd6);
      edge_sample();
      chk("b_rsv6.bv", 32'(b_bv), 32'h0);
      @(negedge clk);
      drive_b(1'b1, 3'd5, 3'd7, 1'b1, 3'd7, 8'h99, 1'b0, 3'd0);
      edge_sample();
      chk_b("b_read57", 8'h44, 8'h00, 2'b00, 1'b1, 6'h00);
      @(negedge clk);
      drive_b(1'b1, 3'd6, 3'd5, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5);
      edge_sample();
      chk_b("b_read65", 8'h00, 8'h44, 2'b10, 1'b1, 6'h20);
      @(negedge clk);
      drive_b(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

      // Mid-cycle reset wipes data, busy bits and read outputs before the next edge.
      drive_a(1'b0, 3'd0, 3'd0, 1'b1, 3'd4, 8'h77, 1'b1, 3'd1);
      edge_sample();
      chk("pre_rst.bv", 32'(a_bv), 32'h06);
      @(negedge clk);
      drive_a(1'b1, 3'd4, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      edge_sample();
      chk_a("pre_rst_read", 8'h77, 8'h00, 2'b10, 1'b1, 8'h06);
      @(negedge clk);
      drive_a(1'b1, 3'd4, 3'd1, 1'b1, 3'd4, 8'h55, 1'b1, 3'd3);
      rst = 1'b1;
      #1;
      chk_a("mid_rst", 8'h00, 8'h00, 2'b00, 1'b0, 8'h00);
      edge_sample();
      chk("rst_edge.bv", 32'(a_bv), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive_a(1'b1, 3'd4, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      edge_sample();
      chk_a("post_rst_read", 8'h00, 8'h00, 2'b00, 1'b1, 8'h00);
      @(negedge clk);
      drive_a(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
